// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_pkg
// Description : Shared constants, FSM state type and address helper for the
//               multi-read-port integer register file.
//               Optional feature macro used by reg_file_mp: RF_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

  localparam int unsigned RF_XLEN = 32;
  localparam int unsigned RF_NREG = 32;
  localparam int unsigned RF_NRD  = 2;

  // Clear sequencer states.
  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  // An address is usable only if it selects an implemented entry; matters
  // when NREG is not a power of two.
  function automatic logic rf_addr_valid(input logic [31:0] addr,
                                         input int unsigned nreg);
    return (addr < nreg);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard
// Description : Per-register busy bits for hazard detection. Priority per
//               entry, high to low: flush clears all, issue sets, writeback
//               clears. Register 0 is never marked busy when ZERO_REG != 0.
// Ports       : clk, rst_n       clock / async active-low reset
//               en_i             updates allowed (register file READY)
//               flush_i          clear every busy bit
//               iss_en_i/addr    mark destination busy
//               wr_en_i/addr     writeback clears busy
//               rd_addr_i        NRD packed lookup addresses
//               rd_busy_o        NRD stored busy bits (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned NREG     = RF_NREG,
  parameter int unsigned NRD      = RF_NRD,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned AW       = $clog2(RF_NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic              iss_en_i,
  input  logic [AW-1:0]     iss_addr_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD-1:0]    rd_busy_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            iss_set;

  assign iss_set = iss_en_i
                 && rf_addr_valid(32'(iss_addr_i), NREG)
                 && !((ZERO_REG != 0) && (iss_addr_i == '0));

  // Set is evaluated after clear so a same-cycle issue to the written
  // register keeps it busy: the newly issued producer is still in flight.
  always_comb begin
    busy_d = busy_q;
    if (en_i) begin
      if (flush_i) begin
        busy_d = '0;
      end else begin
        for (int e = 0; e < int'(NREG); e++) begin
          if (wr_en_i && (wr_addr_i == AW'(e))) begin
            busy_d[e] = 1'b0;
          end
          if (iss_set && (iss_addr_i == AW'(e))) begin
            busy_d[e] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < int'(NRD); i++) begin : g_lookup
    logic [AW-1:0] addr;
    assign addr         = rd_addr_i[i*AW +: AW];
    assign rd_busy_o[i] = rf_addr_valid(32'(addr), NREG) ? busy_q[addr] : 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_mp
// Description : Parametrised multi-read-port integer register file with
//               hardwired-zero x0, post-reset clear sequencer (storage has no
//               reset so it can map to RAM), busy scoreboard and optional
//               write-to-read bypass.
//               Optional feature macro: RF_BYPASS_EN (same-cycle forwarding
//               of writeback data and busy release to the read ports).
// Ports       : clk, rst_n          clock / async active-low reset
//               init_done_o         clear sequence complete
//               rd_addr_i/rd_data_o NRD packed read ports (combinational)
//               rd_busy_o           scoreboard bit per read port
//               wr_en_i/addr/data   writeback
//               iss_en_i/iss_addr_i destination marked busy on issue
//               flush_i             clear all busy bits
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter  int unsigned XLEN     = RF_XLEN,
  parameter  int unsigned NREG     = RF_NREG,
  parameter  int unsigned NRD      = RF_NRD,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned AW       = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                init_done_o,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic                wr_en_i,
  input  logic [AW-1:0]       wr_addr_i,
  input  logic [XLEN-1:0]     wr_data_i,
  input  logic                iss_en_i,
  input  logic [AW-1:0]       iss_addr_i,
  input  logic                flush_i
);

  // --------------------------------------------------------------------------
  // Clear sequencer
  // --------------------------------------------------------------------------
  rf_state_e     state_q;
  rf_state_e     state_d;
  logic [AW-1:0] clr_cnt_q;
  logic [AW-1:0] clr_cnt_d;
  logic          ready;
  logic          clear_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RF_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      RF_CLEAR: begin
        if (clr_cnt_q == AW'(NREG - 1)) begin
          state_d   = RF_READY;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      RF_READY: begin
        state_d = RF_READY;
      end
      default: begin
        state_d   = RF_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    ready       = (state_q == RF_READY);
    clear_we    = (state_q == RF_CLEAR);
    init_done_o = ready;
  end

  // --------------------------------------------------------------------------
  // Storage (no reset: contents are established by the clear sequencer)
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] mem_q [NREG];
  logic            wr_fire;

  assign wr_fire = ready && wr_en_i
                 && rf_addr_valid(32'(wr_addr_i), NREG)
                 && !((ZERO_REG != 0) && (wr_addr_i == '0));

  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (wr_fire) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  logic [NRD-1:0] sb_busy;

  rf_scoreboard #(
    .NREG     (NREG),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (ready),
    .flush_i    (flush_i),
    .iss_en_i   (iss_en_i),
    .iss_addr_i (iss_addr_i),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .rd_addr_i  (rd_addr_i),
    .rd_busy_o  (sb_busy)
  );

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < int'(NRD); i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            addr_ok;
    logic [XLEN-1:0] stored;

    assign addr    = rd_addr_i[i*AW +: AW];
    assign addr_ok = rf_addr_valid(32'(addr), NREG)
                   && !((ZERO_REG != 0) && (addr == '0));
    assign stored  = addr_ok ? mem_q[addr] : '0;

`ifdef RF_BYPASS_EN
    logic bypass;
    logic iss_same;

    // wr_fire already excludes x0 and invalid addresses, so a hit is always
    // a real writeback to this port's register.
    assign bypass   = wr_fire && (wr_addr_i == addr);
    assign iss_same = iss_en_i && (iss_addr_i == addr);

    assign rd_data_o[i*XLEN +: XLEN] = !ready ? '0
                                     : (bypass ? wr_data_i : stored);
    // A same-cycle issue to the same register means a newer producer, so
    // the writeback must not release the busy bit seen by this reader.
    assign rd_busy_o[i] = !ready ? 1'b0
                        : ((bypass && !iss_same) ? 1'b0 : sb_busy[i]);
`else
    assign rd_data_o[i*XLEN +: XLEN] = ready ? stored : '0;
    assign rd_busy_o[i]              = ready ? sb_busy[i] : 1'b0;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_mp
// Description : Directed self-checking bench for reg_file_mp (default
//               parameters: XLEN=32, NREG=32, NRD=2, ZERO_REG=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_done;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        flush;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_file_mp dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_done_o (init_done),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .rd_busy_o   (rd_busy),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .iss_en_i    (iss_en),
    .iss_addr_i  (iss_addr),
    .flush_i     (flush)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  // Counts 32 edges after reset release; init_done must rise exactly on the 32nd.
  task automatic clear_window(input string tag);
    for (int n = 1; n <= 32; n++) begin
      tick();
      checks++;
      if (init_done !== (n == 32)) begin
        errors++;
        $display("FAIL %s init_done edge %0d: got %b want %b", tag, n, init_done, (n == 32));
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0; rd_addr = '0;
    #2;
    checks++;
    if (init_done !== 1'b0 || rd_busy !== 2'b00 || rd_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_state: init_done=%b busy=%b data=%h want 0/00/0", init_done, rd_busy, rd_data);
    end
    tick();
    rst_n = 1'b1;
    // Writes and issues during clear must be ignored.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFF_FFFF;
    iss_en = 1'b1; iss_addr = 5'd2;
    for (int n = 1; n <= 32; n++) begin
      set_rd(5'(n), 5'd3);
      #1;
      checks++;
      if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
        errors++;
        $display("FAIL clear_reads cycle %0d: data=%h busy=%b want 0/00", n, rd_data, rd_busy);
      end
      @(posedge clk);
      #1;
      if (n == 32) begin
        wr_en = 1'b0; iss_en = 1'b0;
      end
      checks++;
      if (init_done !== (n == 32)) begin
        errors++;
        $display("FAIL init_done edge %0d: got %b want %b", n, init_done, (n == 32));
      end
    end
    for (int a = 0; a < 16; a++) begin
      set_rd(5'(2 * a), 5'(2 * a + 1));
      #1;
      checks++;
      if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
        errors++;
        $display("FAIL post_clear x%0d/x%0d: data=%h busy=%b want 0/00", 2 * a, 2 * a + 1, rd_data, rd_busy);
      end
    end
  endtask

  task automatic test_write();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    tick();
    wr_en = 1'b0;
    set_rd(5'd5, 5'd0);
    #1;
    checks++;
    if (rd_data !== {32'h0, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL write_x5: got %h want %h", rd_data, {32'h0, 32'hDEAD_BEEF});
    end
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000_1234;
    tick();
    wr_en = 1'b0;
    set_rd(5'd0, 5'd5);
    #1;
    checks++;
    if (rd_data !== {32'hDEAD_BEEF, 32'h0}) begin
      errors++;
      $display("FAIL write_x0_ignored: got %h want %h", rd_data, {32'hDEAD_BEEF, 32'h0});
    end
  endtask

  task automatic test_bypass();
    set_rd(5'd7, 5'd5);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5;
    #1;
    checks++;
    if (rd_data[31:0] !== (BYP ? 32'hA5A5_A5A5 : 32'h0)) begin
      errors++;
      $display("FAIL same_cycle_x7: got %h want %h", rd_data[31:0], (BYP ? 32'hA5A5_A5A5 : 32'h0));
    end
    tick();
    wr_en = 1'b0;
    #1;
    checks++;
    if (rd_data[31:0] !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL next_cycle_x7: got %h want a5a5a5a5", rd_data[31:0]);
    end
  endtask

  task automatic test_busy();
    set_rd(5'd9, 5'd0);
    iss_en = 1'b1; iss_addr = 5'd9;
    #1;
    checks++;
    if (rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL busy_before_issue_edge: got %b want 00", rd_busy);
    end
    tick();
    iss_en = 1'b0;
    #1;
    checks++;
    if (rd_busy !== 2'b01) begin
      errors++;
      $display("FAIL busy_after_issue: got %b want 01", rd_busy);
    end
    tick();
    checks++;
    if (rd_busy !== 2'b01) begin
      errors++;
      $display("FAIL busy_held: got %b want 01", rd_busy);
    end
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0099;
    #1;
    checks++;
    if (rd_busy[0] !== !BYP || rd_data[31:0] !== (BYP ? 32'h99 : 32'h0)) begin
      errors++;
      $display("FAIL wb_cycle_x9: busy=%b data=%h want %b/%h", rd_busy[0], rd_data[31:0], !BYP, (BYP ? 32'h99 : 32'h0));
    end
    tick();
    wr_en = 1'b0;
    #1;
    checks++;
    if (rd_busy !== 2'b00 || rd_data[31:0] !== 32'h99) begin
      errors++;
      $display("FAIL after_wb_x9: busy=%b data=%h want 00/00000099", rd_busy, rd_data[31:0]);
    end
    iss_en = 1'b1; iss_addr = 5'd9;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0077;
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL iss_wb_same_cycle: busy=%b want 0", rd_busy[0]);
    end
    tick();
    iss_en = 1'b0; wr_en = 1'b0;
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h77) begin
      errors++;
      $display("FAIL iss_wb_after: busy=%b data=%h want 1/00000077", rd_busy[0], rd_data[31:0]);
    end
  endtask

  task automatic test_flush();
    iss_en = 1'b1;
    iss_addr = 5'd3; tick();
    iss_addr = 5'd4; tick();
    iss_addr = 5'd6; tick();
    iss_addr = 5'd0; tick();
    iss_en = 1'b0;
    set_rd(5'd3, 5'd4);
    #1;
    checks++;
    if (rd_busy !== 2'b11) begin
      errors++;
      $display("FAIL busy_x3_x4: got %b want 11", rd_busy);
    end
    set_rd(5'd0, 5'd6);
    #1;
    checks++;
    if (rd_busy !== 2'b10) begin
      errors++;
      $display("FAIL busy_x0_x6: got %b want 10", rd_busy);
    end
    flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd8;
    tick();
    flush = 1'b0; iss_en = 1'b0;
    set_rd(5'd3, 5'd4);
    #1;
    checks++;
    if (rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL flush_x3_x4: got %b want 00", rd_busy);
    end
    set_rd(5'd6, 5'd8);
    #1;
    checks++;
    if (rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL flush_x6_x8: got %b want 00", rd_busy);
    end
    set_rd(5'd9, 5'd0);
    #1;
    checks++;
    if (rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL flush_x9: got %b want 00", rd_busy);
    end
  endtask

  task automatic test_reset_mid();
    // Mid-clear restart.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int n = 1; n <= 10; n++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (init_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_clear_reset: init_done=%b want 0", init_done);
    end
    tick();
    rst_n = 1'b1;
    clear_window("restart_clear");
    // Mid-READY reset after writes and an issue.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hCAFE_F00D;
    tick();
    wr_en = 1'b0; iss_en = 1'b1; iss_addr = 5'd12;
    tick();
    iss_en = 1'b0;
    set_rd(5'd5, 5'd12);
    #1;
    checks++;
    if (rd_data[31:0] !== 32'hCAFE_F00D || rd_busy !== 2'b10) begin
      errors++;
      $display("FAIL pre_reset_state: data=%h busy=%b want cafef00d/10", rd_data[31:0], rd_busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (init_done !== 1'b0 || rd_busy !== 2'b00 || rd_data !== 64'h0) begin
      errors++;
      $display("FAIL mid_ready_reset: init_done=%b busy=%b data=%h want 0/00/0", init_done, rd_busy, rd_data);
    end
    tick();
    rst_n = 1'b1;
    clear_window("ready_restart");
    #1;
    checks++;
    if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL data_after_restart: data=%h busy=%b want 0/00", rd_data, rd_busy);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_bypass();
    test_busy();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port integer register file for the RISC-V core, replacing the fixed 32x32 two-read-port file in the decode/writeback path. It adds configurable width, depth and read-port count, hardwired-zero x0, a post-reset clear sequencer (storage is not flop-reset, so it maps to RAM), a per-register busy scoreboard for hazard detection, and optional write-to-read bypass.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of registers (≥2); AW = $clog2(NREG) derived
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- init_done  out  1  high once clear sequence complete
- rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data, combinational
- rd_busy  out  NRD  scoreboard bit of each rd_addr, combinational
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback address
- wr_data  in  XLEN  writeback data
- iss_en  in  1  instruction issued with destination iss_addr
- iss_addr  in  AW  destination being marked busy
- flush  in  1  pipeline flush, clears all busy bits

## Operation
- FSM states CLEAR, READY. rst_n low: state=CLEAR, clr_cnt=0, busy=0, init_done=0 immediately (async).
- CLEAR: each edge writes 0 to entry clr_cnt, clr_cnt++; on edge writing NREG-1 → READY. wr_en, iss_en, flush ignored; rd_data forced 0, rd_busy forced 0.
- rst_n asserted mid-CLEAR or mid-READY: restart from CLEAR, clr_cnt=0.
- READY write: wr_en & addr valid & !(ZERO_REG & wr_addr==0) → entry updated on edge.
- Reads: rd_data[i] = entry[rd_addr[i]]; 0 if rd_addr[i]==0 and ZERO_REG, or rd_addr[i] ≥ NREG.
- Scoreboard, priority high→low per entry: flush clears all; iss_en sets busy[iss_addr]; wr_en clears busy[wr_addr]. iss_en and wr_en to same address same cycle → busy stays 1 (newer producer). flush same cycle as iss_en → all 0, iss dropped.
- Address ≥ NREG on wr_addr/iss_addr: ignored. Register 0 with ZERO_REG: never set busy.

## Timing
- Read path and rd_busy fully combinational, zero latency.
- Write visible on read port the cycle after the write edge (without bypass).
- init_done rises after exactly NREG rising edges following rst_n release; stays high until next reset.
- busy set by iss_en visible on rd_busy the cycle after the issue edge.

## Configuration
- RF_BYPASS_EN defined: when READY, wr_en, valid nonzero-or-non-ZERO_REG wr_addr equals rd_addr[i], rd_data[i]=wr_data and rd_busy[i]=0 in the same cycle (unless iss_en to same address also asserted: rd_busy[i] stays as stored).
- Undefined: no forwarding; rd_data shows old value and rd_busy stays 1 until the cycle after the write.

## Structure
- reg_file_pkg: default XLEN/NREG constants, rf_state_e enum (CLEAR, READY), helper function for address validity.
- One sub-module rf_scoreboard: busy vector, set/clear/flush priority, per-port lookup; top holds storage array, clear FSM, read muxing and bypass.

## Test plan
- Reset release, NREG=32: init_done low for 32 edges, high on 33rd cycle; all 32 reads return 0 during and after clear.
- Write x5=0xDEADBEEF, read port0=x5, port1=x0 next cycle → 0xDEADBEEF, 0; write x0=0x1234 → x0 still reads 0.
- Same-cycle write x7=0xA5A5A5A5 with rd_addr0=x7: bypass build → 0xA5A5A5A5 that cycle; non-bypass → old value, new value next cycle.
- iss_en x9, then wr_en x9 two cycles later: rd_busy=1 for reads of x9 in between, 0 after; iss_en+wr_en x9 same cycle → busy stays 1.
- Set busy on x3,x4,x6 then flush with iss_en x8 same cycle → all busy 0, x8 not busy.
- Drop rst_n mid-clear at clr_cnt=10 and mid-READY after writes → init_done 0 immediately, busy cleared, full 32-cycle clear restarts, prior data reads 0.
